// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, false-start
// rejection, parity/framing/overrun flags and a valid/ready output register.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 uart_rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);
  localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic          ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, DONE, BRK} state_t;

  state_t               state;
  logic                 sync1, sync2, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        samp_cnt;
  logic                 v_lo, v_mid;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_n, ferr_n;
  logic                 rx_s, tick, at_vote, at_end, vote;

  always_comb begin
    rx_s    = sync2;
    tick    = (div_cnt == DW'(DIV - 1));
    at_vote = tick && (samp_cnt == S_HI);
    at_end  = tick && (samp_cnt == S_END);
    vote    = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);
  end

  assign rx_busy = (state != IDLE);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      rx_prev     <= 1'b1;
      div_cnt     <= '0;
      samp_cnt    <= '0;
      v_lo        <= 1'b1;
      v_mid       <= 1'b1;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shreg       <= '0;
      perr_n      <= 1'b0;
      ferr_n      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      rx_prev <= sync2;

      // Bit timing only runs inside a frame so every frame starts phase-aligned to its edge.
      if (state == IDLE) begin
        div_cnt  <= '0;
        samp_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + SW'(1);
      end
      if (tick && samp_cnt == S_LO)  v_lo  <= rx_s;
      if (tick && samp_cnt == S_MID) v_mid <= rx_s;

      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end

      case (state)
        IDLE: if (rx_prev && !rx_s) begin
          state    <= START;
          perr_n   <= 1'b0;
          ferr_n   <= 1'b0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
        end
        START: begin
          if (tick && samp_cnt == S_MID && rx_s) state <= IDLE;
          else if (at_end)                       state <= DATA;
        end
        DATA: begin
          if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
          end
        end
        PAR: begin
          if (at_vote) perr_n <= (((^shreg) ^ vote) != ODD);
          if (at_end)  state  <= STOP;
        end
        STOP: begin
          // Leave on the last stop-bit vote so a back-to-back start edge is not missed.
          if (at_vote) begin
            ferr_n <= ferr_n | ~vote;
            if (stop_cnt == 1'(STOP_BITS - 1)) state <= DONE;
          end
          if (at_end) stop_cnt <= ~stop_cnt;
        end
        DONE: begin
          if (!rx_valid || rx_ready) begin
            rx_data    <= shreg;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            rx_valid   <= 1'b1;
          end else begin
            overrun_err <= 1'b1;
          end
          state <= ferr_n ? BRK : IDLE;
        end
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: frames are generated bit by bit, expected words/flags come
// from a frame-level model, received words are collected by a handshake monitor.
module tb_uart_rx_param;
  localparam int CLK_FREQ = 64_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT      = CLK_FREQ / BAUD;  // sysclk cycles per bit (DIV=4)

  typedef struct packed {logic [7:0] d; logic pe; logic fe;} rx_t;

  logic clk = 1'b0, reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] da, db;
  logic va, pea, fea, oa, ba, vb, peb, feb, ob, bb;
  int checks = 0, failures = 0;
  rx_t qa[$], qb[$], ea[$], eb[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) dut_a (
    .sysclk(clk), .reset(reset), .uart_rx(rx_a), .rx_ready(ready_a), .rx_data(da),
    .rx_valid(va), .parity_err(pea), .frame_err(fea), .overrun_err(oa), .rx_busy(ba));

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .OVERSAMPLE(OS)) dut_b (
    .sysclk(clk), .reset(reset), .uart_rx(rx_b), .rx_ready(ready_b), .rx_data(db),
    .rx_valid(vb), .parity_err(peb), .frame_err(feb), .overrun_err(ob), .rx_busy(bb));

  always @(negedge clk) begin
    if (!reset && va && ready_a) qa.push_back(rx_t'{da, pea, fea});
    if (!reset && vb && ready_b) qb.push_back(rx_t'{db, peb, feb});
  end

  task automatic set_line(input int d, input logic v);
    if (d == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic drive_bit(input int d, input logic v, input bit glitch);
    for (int c = 0; c < BIT; c++) begin
      if (glitch && c == BIT / 2) set_line(d, ~v);
      else set_line(d, v);
      @(posedge clk); #1;
    end
  endtask

  // Model: even parity bit = XOR of data, odd = its inverse; error when the line bit differs.
  task automatic send_frame(input int d, input logic [7:0] data, input int pmode, input bit flip,
                            input int nstop, input logic stop_val, input int gbit, input bit push);
    logic pb;
    rx_t  e;
    pb   = (^data) ^ (pmode == 1) ^ flip;
    e.d  = data;
    e.pe = (pmode != 0) && flip;
    e.fe = ~stop_val;
    if (push) begin
      if (d == 0) ea.push_back(e); else eb.push_back(e);
    end
    drive_bit(d, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, data[i], i == gbit);
    if (pmode != 0) drive_bit(d, pb, 1'b0);
    for (int s = 0; s < nstop; s++) drive_bit(d, (s == nstop - 1) ? stop_val : 1'b1, 1'b0);
  endtask

  task automatic idle(input int d, input int nbits);
    set_line(d, 1'b1);
    repeat (nbits * BIT) @(posedge clk);
    #1;
  endtask

  task automatic get_rx(input int d, output bit found, output rx_t r);
    r = '0;
    found = 0;
    for (int i = 0; i < 2 * BIT; i++) begin
      if (d == 0 && qa.size() != 0) begin r = qa.pop_front(); found = 1; break; end
      if (d == 1 && qb.size() != 0) begin r = qb.pop_front(); found = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic get_exp(input int d, output rx_t e);
    e = '1;
    if (d == 0 && ea.size() != 0) e = ea.pop_front();
    if (d == 1 && eb.size() != 0) e = eb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({va, pea, fea, oa, ba, da} !== 13'h0) begin
      failures++; $display("FAIL reset_a got=%h exp=0", {va, pea, fea, oa, ba, da});
    end
    checks++;
    if ({vb, peb, feb, ob, bb, db} !== 13'h0) begin
      failures++; $display("FAIL reset_b got=%h exp=0", {vb, peb, feb, ob, bb, db});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(0, 1);
  endtask

  task automatic test_basic();
    bit found; rx_t got, exp;
    send_frame(0, 8'h55, 0, 0, 1, 1'b1, -1, 1);
    get_rx(0, found, got); get_exp(0, exp);
    checks++;
    if (!found || got !== exp) begin
      failures++; $display("FAIL basic_55 got=%h found=%0d exp=%h", got, found, exp);
    end
    idle(0, 1);
    checks++;
    if (va !== 1'b0 || qa.size() != 0) begin
      failures++; $display("FAIL basic_pulse valid=%b extra=%0d exp valid=0 extra=0", va, qa.size());
    end
  endtask

  task automatic test_parity();
    bit found; rx_t got, exp;
    for (int f = 0; f < 2; f++) begin
      send_frame(1, 8'hA3, 2, f[0], 2, 1'b1, -1, 1);
      get_rx(1, found, got); get_exp(1, exp);
      checks++;
      if (!found || got !== exp) begin
        failures++; $display("FAIL parity_a3_flip%0d got=%h found=%0d exp=%h", f, got, found, exp);
      end
      idle(1, 1);
    end
  endtask

  task automatic test_random();
    bit found; rx_t got, exp;
    logic [7:0] data;
    bit flip; logic sv;
    for (int n = 0; n < 8; n++) begin
      data = 8'($urandom);
      sv   = ($urandom_range(0, 3) != 0);
      send_frame(0, data, 0, 0, 1, sv, -1, 1);
      get_rx(0, found, got); get_exp(0, exp);
      checks++;
      if (!found || got !== exp) begin
        failures++; $display("FAIL random_a%0d got=%h found=%0d exp=%h", n, got, found, exp);
      end
      idle(0, 1);
    end
    for (int n = 0; n < 8; n++) begin
      data = 8'($urandom);
      flip = $urandom_range(0, 1) != 0;
      send_frame(1, data, 2, flip, 2, 1'b1, -1, 1);
      get_rx(1, found, got); get_exp(1, exp);
      checks++;
      if (!found || got !== exp) begin
        failures++; $display("FAIL random_b%0d got=%h found=%0d exp=%h", n, got, found, exp);
      end
    end
    idle(1, 1);
  endtask

  task automatic test_break();
    bit found; rx_t got, exp;
    send_frame(0, 8'h3C, 0, 0, 1, 1'b0, -1, 1);
    get_rx(0, found, got); get_exp(0, exp);
    checks++;
    if (!found || got !== exp) begin
      failures++; $display("FAIL break_3c got=%h found=%0d exp=%h", got, found, exp);
    end
    set_line(0, 1'b0);
    repeat (20 * BIT) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ba !== 1'b1 || qa.size() != 0 || oa !== 1'b0) begin
      failures++; $display("FAIL break_hold busy=%b frames=%0d ovr=%b exp busy=1 frames=0 ovr=0", ba, qa.size(), oa);
    end
    idle(0, 2);
    checks++;
    if (ba !== 1'b0) begin
      failures++; $display("FAIL break_release busy=%b exp=0", ba);
    end
    send_frame(0, 8'h81, 0, 0, 1, 1'b1, -1, 1);
    get_rx(0, found, got); get_exp(0, exp);
    checks++;
    if (!found || got !== exp) begin
      failures++; $display("FAIL break_81 got=%h found=%0d exp=%h", got, found, exp);
    end
    idle(0, 1);
  endtask

  task automatic test_overrun();
    ready_a = 1'b0;
    send_frame(0, 8'h12, 0, 0, 1, 1'b1, -1, 0);
    checks++;
    if (va !== 1'b1 || da !== 8'h12 || oa !== 1'b0) begin
      failures++; $display("FAIL overrun_first valid=%b data=%h ovr=%b exp 1/12/0", va, da, oa);
    end
    send_frame(0, 8'h34, 0, 0, 1, 1'b1, -1, 0);
    idle(0, 1);
    checks++;
    if (va !== 1'b1 || da !== 8'h12 || oa !== 1'b1) begin
      failures++; $display("FAIL overrun_second valid=%b data=%h ovr=%b exp 1/12/1", va, da, oa);
    end
    ready_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (va !== 1'b0 || oa !== 1'b1 || qa.size() != 1) begin
      failures++; $display("FAIL overrun_drain valid=%b ovr=%b frames=%0d exp 0/1/1", va, oa, qa.size());
    end
    qa.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_glitch();
    bit found, saw_busy; rx_t got, exp;
    saw_busy = 0;
    set_line(0, 1'b0);
    for (int c = 0; c < 4 * BIT; c++) begin
      if (c == BIT / 3) set_line(0, 1'b1);
      @(negedge clk);
      if (ba) saw_busy = 1;
    end
    checks++;
    if (!saw_busy || ba !== 1'b0 || qa.size() != 0) begin
      failures++; $display("FAIL glitch saw_busy=%0d busy=%b frames=%0d exp 1/0/0", saw_busy, ba, qa.size());
    end
    @(posedge clk); #1;
    send_frame(0, 8'hF0, 0, 0, 1, 1'b1, -1, 1);
    get_rx(0, found, got); get_exp(0, exp);
    checks++;
    if (!found || got !== exp) begin
      failures++; $display("FAIL glitch_f0 got=%h found=%0d exp=%h", got, found, exp);
    end
    idle(0, 1);
  endtask

  task automatic test_mid_reset();
    bit found; rx_t got, exp;
    send_frame(0, 8'h00, 0, 0, 1, 1'b1, 3, 1);
    get_rx(0, found, got); get_exp(0, exp);
    checks++;
    if (!found || got !== exp) begin
      failures++; $display("FAIL spike_00 got=%h found=%0d exp=%h", got, found, exp);
    end
    idle(0, 1);
    fork
      send_frame(0, 8'hF0, 0, 0, 1, 1'b1, -1, 0);
      begin
        repeat (6 * BIT + BIT / 2) @(posedge clk);
        #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
      end
    join
    idle(0, 1);
    @(negedge clk);
    checks++;
    if ({va, pea, fea, oa, ba, da} !== 13'h0 || qa.size() != 0) begin
      failures++; $display("FAIL mid_reset got=%h frames=%0d exp=0 frames=0", {va, pea, fea, oa, ba, da}, qa.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_random();
    test_break();
    test_overrun();
    test_glitch();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
